// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - valid/ready front end that drives the serial adder's start/done protocol
// Optional WAIT timeout compiled in with SERIAL_SEQ_TIMEOUT_EN.
module serial_add_sequencer #(
    parameter int OPW     = 8,
    parameter int TIMEOUT = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_a,
    input  logic [OPW-1:0] in_b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [OPW-1:0] res_sum,
    output logic           res_err,
    output logic           busy,
    output logic           adder_start,
    output logic [15:0]    adder_a,
    output logic [15:0]    adder_b,
    input  logic [15:0]    adder_out,
    input  logic           adder_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [OPW-1:0] a_q, a_d;
    logic [OPW-1:0] b_q, b_d;
    logic [OPW-1:0] sum_q, sum_d;
    logic           start_q, start_d;

`ifdef SERIAL_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    logic unused_adder_hi;
    assign unused_adder_hi = ^adder_out;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        start_d = 1'b0;
`ifdef SERIAL_SEQ_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    start_d = 1'b1;
                    state_d = S_START;
`ifdef SERIAL_SEQ_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (adder_done) begin
                    sum_d   = adder_out[OPW-1:0];
                    state_d = S_HOLD;
`ifdef SERIAL_SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
                end else begin
                    // Abort on the edge where the count of idle WAIT cycles reaches TIMEOUT.
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        sum_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_HOLD;
                    end
`endif
                end
            end
            S_HOLD: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // start resets high so the adder stays cleared while rst is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            start_q <= 1'b1;
`ifdef SERIAL_SEQ_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            start_q <= start_d;
`ifdef SERIAL_SEQ_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign res_valid   = (state_q == S_HOLD);
    assign res_sum     = sum_q;
    assign adder_start = start_q;
    assign adder_a     = 16'(a_q);
    assign adder_b     = 16'(b_q);
`ifdef SERIAL_SEQ_TIMEOUT_EN
    assign res_err     = err_q;
`else
    assign res_err     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - directed bench for serial_add_sequencer with a 9-cycle adder model
module tb_serial_add_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = 8'h00;
    logic [7:0]  in_b = 8'h00;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_sum;
    logic        res_err;
    logic        busy;
    logic        adder_start;
    logic [15:0] adder_a;
    logic [15:0] adder_b;
    logic [15:0] adder_out;
    logic        adder_done = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    int mcnt     = 0;
    bit never_done = 1'b0;

    serial_add_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_err(res_err),
        .busy(busy), .adder_start(adder_start), .adder_a(adder_a), .adder_b(adder_b),
        .adder_out(adder_out), .adder_done(adder_done)
    );

    always #5 clk = ~clk;

    // Adder model: done rises 9 cycles after start falls.
    assign adder_out = {8'h00, adder_a[7:0] + adder_b[7:0]};
    always @(posedge clk) begin
        if (adder_start) begin
            mcnt       <= 0;
            adder_done <= 1'b0;
        end else begin
            if (mcnt < 9) mcnt <= mcnt + 1;
            adder_done <= !never_done && (mcnt >= 8);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int lat = 0;
        while (res_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        chk(tag, lat, exp_lat);
    endtask

    initial begin
        int lat;
        bit stable;
        bit seen;

        // Reset state
        tick();
        tick();
        chk("rst_start", adder_start, 1'b1);
        chk("rst_adder_a", adder_a, 16'h0000);
        chk("rst_adder_b", adder_b, 16'h0000);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_sum", res_sum, 8'h00);
        chk("rst_res_err", res_err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        chk("start_drop", adder_start, 1'b0);

        // Basic add with res_ready already high
        in_a = 8'h25; in_b = 8'h1A; in_valid = 1'b1; res_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("basic_start", adder_start, 1'b1);
        chk("basic_in_ready", in_ready, 1'b0);
        chk("basic_busy", busy, 1'b1);
        chk("basic_adder_a", adder_a, 16'h0025);
        lat = 0; seen = 1'b0;
        while (res_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
            if (adder_start) seen = 1'b1;
        end
        chk("basic_latency", lat, 11);
        chk("basic_extra_start", seen, 1'b0);
        chk("basic_sum", res_sum, 8'h3F);
        chk("basic_err", res_err, 1'b0);
        tick();
        chk("basic_one_valid", res_valid, 1'b0);
        chk("basic_idle", in_ready, 1'b1);

        // Wrap with backpressure and a queued second operation
        res_ready = 1'b0;
        in_a = 8'hF0; in_b = 8'h20; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0; stable = 1'b1;
        while (res_valid !== 1'b1 && lat < 100) begin
            if (adder_a !== 16'h00F0 || adder_b !== 16'h0020) stable = 1'b0;
            tick();
            lat++;
        end
        chk("wrap_latency", lat, 11);
        chk("wrap_operands_stable", stable, 1'b1);
        chk("wrap_sum", res_sum, 8'h10);
        in_a = 8'h03; in_b = 8'h04; in_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (res_sum !== 8'h10 || in_ready !== 1'b0 || res_valid !== 1'b1) stable = 1'b0;
        end
        chk("bp_hold_stable", stable, 1'b1);
        res_ready = 1'b1;
        tick();
        chk("bp_no_early_accept", adder_start, 1'b0);
        chk("bp_back_idle", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("bp_second_start", adder_start, 1'b1);
        chk("bp_second_a", adder_a, 16'h0003);
        wait_result("bp_second_latency", 11);
        chk("bp_second_sum", res_sum, 8'h07);
        tick();

        // Reset four cycles into WAIT
        in_a = 8'h11; in_b = 8'h22; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_start", adder_start, 1'b1);
        chk("mid_rst_valid", res_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_start_drop", adder_start, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid !== 1'b0) seen = 1'b1;
        end
        chk("mid_rst_no_result", seen, 1'b0);

`ifdef SERIAL_SEQ_TIMEOUT_EN
        // Adder never completes: abort after 32 WAIT cycles
        never_done = 1'b1;
        in_a = 8'h55; in_b = 8'h66; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_result("to_latency", 33);
        chk("to_err", res_err, 1'b1);
        chk("to_sum", res_sum, 8'h00);
        never_done = 1'b0;
        tick();
        in_a = 8'h80; in_b = 8'h81; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_result("to_next_latency", 11);
        chk("to_next_err", res_err, 1'b0);
        chk("to_next_sum", res_sum, 8'h01);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
